// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared mode encoding for the programmable LUT neuron
package lut_neuron_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} mode_e;
endpackage

// File: rtl/lut_neuron_table.sv
// lut_neuron_table: resettable flop-array truth table, async read, sync write
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS = 6,
  parameter int OUT_BITS = 2,
  parameter logic [(2**IN_BITS)*OUT_BITS-1:0] INIT_TABLE = {16{8'hF0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);
  logic [OUT_BITS-1:0] mem_q [2**IN_BITS];
  assign rdata_o = mem_q[raddr_i];
  // reset reloads the initial truth table; a write replaces one entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**IN_BITS; i++) mem_q[i] <= INIT_TABLE[OUT_BITS*i +: OUT_BITS];
    else if (we_i)
      mem_q[waddr_i] <= wdata_i;
endmodule

// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog: LogicNets neuron with a runtime-reloadable table and valid/ready output
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS = 6,
  parameter int OUT_BITS = 2,
  parameter logic [(2**IN_BITS)*OUT_BITS-1:0] INIT_TABLE = {16{8'hF0}},
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_BITS-1:0]  in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_BITS-1:0] out_data_o,
  input  logic                cfg_start_i,
  input  logic                cfg_we_i,
  input  logic [IN_BITS-1:0]  cfg_addr_i,
  input  logic [OUT_BITS-1:0] cfg_data_i,
  input  logic                cfg_done_i,
  output logic [MODE_W-1:0]   mode_o,
  output logic [CNT_BITS-1:0] xfer_count_o
);
  mode_e               mode_q, mode_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [OUT_BITS-1:0] rdata;
  logic                accept, xfer;
  // a start request blocks the same-cycle accept so nothing new enters before draining
  assign in_ready_o   = (mode_q == RUN) && !cfg_start_i && (!out_valid_q || out_ready_i);
  assign accept       = in_valid_i && in_ready_o;
  assign xfer         = out_valid_q && out_ready_i;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign mode_o       = mode_q;
  assign xfer_count_o = cnt_q;
  lut_neuron_table #(
    .IN_BITS(IN_BITS),
    .OUT_BITS(OUT_BITS),
    .INIT_TABLE(INIT_TABLE)
  ) u_table (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(mode_q == LOAD && cfg_we_i),
    .waddr_i(cfg_addr_i),
    .wdata_i(cfg_data_i),
    .raddr_i(in_data_i),
    .rdata_o(rdata)
  );
  // mode sequencing, output register next state and saturating handshake counter
  always_comb begin
    mode_d      = (mode_q == RUN   && cfg_start_i)  ? DRAIN :
                  (mode_q == DRAIN && !out_valid_q) ? LOAD  :
                  (mode_q == LOAD  && cfg_done_i)   ? RUN   : mode_q;
    out_valid_d = accept ? 1'b1 : xfer ? 1'b0 : out_valid_q;
    out_data_d  = accept ? rdata : out_data_q;
    cnt_d       = (xfer && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers; reset drops any in-flight word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q      <= RUN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
endmodule

// File: tb/tb_lut_neuron_prog.sv
// tb_lut_neuron_prog: scoreboard bench with a behavioural table model
module tb_lut_neuron_prog;
  import lut_neuron_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cfg_start = 1'b0, cfg_we = 1'b0, cfg_done = 1'b0;
  logic [5:0] in_data = '0, cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [1:0] out_data, mode, out_data4, mode4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  logic [1:0] ref_tbl [64];
  logic [1:0] exp_q [$];
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  lut_neuron_prog dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .cfg_start_i(cfg_start),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_done_i(cfg_done),
    .mode_o(mode), .xfer_count_o(cnt));

  lut_neuron_prog #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_data_i(in_data),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_data_o(out_data4), .cfg_start_i(cfg_start),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_done_i(cfg_done),
    .mode_o(mode4), .xfer_count_o(cnt4));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) ref_tbl[i] = i[1] ? 2'b11 : 2'b00;
    exp_q.delete();
    exp_cnt = 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {in_valid, cfg_start, cfg_we, cfg_done} = '0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic lookup(input logic [5:0] a, input string name);
    in_valid = 1'b1;
    in_data  = a;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk(name, out_data, ref_tbl[a]);
    cyc();
  endtask

  task automatic enter_load();
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int k = 0; k < 30 && mode != LOAD; k++) cyc();
    chk("reach_load", mode, LOAD);
  endtask

  task automatic write_cfg(input logic [5:0] a, input logic [1:0] d, input logic done);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    cfg_done = done;
    ref_tbl[a] = d;
    cyc();
    cfg_we = 1'b0;
    cfg_done = 1'b0;
  endtask

  task automatic chk_cnt(input string name);
    chk(name, cnt, exp_cnt);
    chk({name, "_sat4"}, cnt4, exp_cnt > 15 ? 15 : exp_cnt);
  endtask

  // expected word is queued when an input is taken
  always @(negedge clk)
    if (rst_n && in_valid && in_ready) exp_q.push_back(ref_tbl[in_data]);

  // every output handshake is matched against the oldest expected word
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: output %0d with nothing expected", out_data);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (out_data != e) begin
          n_bad++;
          $display("FAIL sb_data: got %0d expected %0d", out_data, e);
        end
      end
      exp_cnt++;
    end

  initial begin
    model_reset();
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mode", mode, RUN);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", cnt, 0);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data = 6'(i);
      @(negedge clk);
      chk("stream_ready", in_ready, 1);
      if (i < 2) chk("stream_latency", out_valid, i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("stream_cnt", cnt, 64);
    chk_cnt("stream_model_cnt");
    chk("stream_idle", out_valid, 0);

    in_valid = 1'b1;
    in_data = 6'd2;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 3);
      chk("bp_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("bp_cnt", cnt, 65);
    chk("bp_clear", out_valid, 0);

    in_valid = 1'b1;
    in_data = 6'd7;
    out_ready = 1'b0;
    cyc();
    in_data = 6'd9;
    cfg_start = 1'b1;
    @(negedge clk);
    chk("start_refuse", in_ready, 0);
    cyc();
    cfg_start = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drain_hold", mode, DRAIN);
      chk("drain_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("drain_emptied", out_valid, 0);
    chk("drain_still", mode, DRAIN);
    cyc();
    @(negedge clk);
    chk("load_mode", mode, LOAD);
    chk("load_ready", in_ready, 0);
    cyc();
    write_cfg(6'd0, 2'b10, 1'b0);
    write_cfg(6'd63, 2'b01, 1'b1);
    @(negedge clk);
    chk("load_exit", mode, RUN);
    cyc();
    lookup(6'd0, "reload_0");
    lookup(6'd63, "reload_63");

    cfg_we = 1'b1;
    cfg_addr = 6'd5;
    cfg_data = 2'b11;
    cfg_done = 1'b1;
    cyc();
    {cfg_we, cfg_done} = '0;
    @(negedge clk);
    chk("illegal_mode", mode, RUN);
    cyc();
    lookup(6'd5, "illegal_5");

    enter_load();
    cfg_we = 1'b1;
    cfg_addr = 6'd0;
    cfg_data = 2'b11;
    cyc();
    cfg_we = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rstload_mode", mode, RUN);
    chk("rstload_valid", out_valid, 0);
    chk_cnt("rstload_cnt");
    cyc();
    lookup(6'd0, "rstload_0");

    in_valid = 1'b1;
    in_data = 6'd3;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rstxfer_valid", out_valid, 0);
    cyc();

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 80; k++) begin
        in_valid = 1'($urandom);
        in_data = 6'($urandom);
        out_ready = ($urandom % 4) != 0;
        cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      enter_load();
      for (int w = 0; w < 5; w++) write_cfg(6'($urandom_range(0, 7)), 2'($urandom), w == 4);
      @(negedge clk);
      chk("rand_exit", mode, RUN);
      cyc();
      for (int a = 0; a < 8; a++) lookup(6'(a), "rand_readback");
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk_cnt("final_cnt");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
Parametrised LogicNets neuron whose truth table can be reloaded at runtime, replacing fixed per-neuron ROM case tables. The lookup is registered and carries a valid/ready handshake, so it can be chained layer-to-layer with backpressure. A small mode FSM drains in-flight data before allowing table rewrites. It sits in each layer wrapper in place of a generated fixed-table neuron.

Parameters:
IN_BITS, 6, lookup address width; table depth is 2**IN_BITS.
OUT_BITS, 2, width of each table entry and of out_data.
INIT_TABLE, {16{8'hF0}} (sized (2**IN_BITS)*OUT_BITS), reset contents; entry i occupies bits [OUT_BITS*i +: OUT_BITS]. The default gives entry i = 2'b11 when i[1]=1, else 2'b00.
CNT_BITS, 16, width of the saturating transfer counter.

Ports:
clk  in  1  sole clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  block accepts in_data this cycle.
in_data  in  IN_BITS  lookup address.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
out_data  out  OUT_BITS  table[in_data], registered.
cfg_start  in  1  request to enter load mode (pulse).
cfg_we  in  1  table write strobe, honoured only in LOAD.
cfg_addr  in  IN_BITS  write address.
cfg_data  in  OUT_BITS  write data.
cfg_done  in  1  leave load mode (pulse).
mode  out  2  current FSM state: RUN=0, DRAIN=1, LOAD=2.
xfer_count  out  CNT_BITS  count of output handshakes, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert): table <= INIT_TABLE, mode=RUN, out_valid=0, out_data=0, xfer_count=0.
- Input acceptance: in_ready = (mode==RUN) && !cfg_start && (!out_valid || out_ready). This path is combinational from out_ready and cfg_start.
- An accept (in_valid && in_ready) loads out_data <= table[in_data] and sets out_valid=1 at the next edge. Latency is exactly 1 cycle. Full throughput is 1 word/cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, out_data and out_valid are stable.
- Clear: on out_valid && out_ready with no new accept, out_valid <= 0.
- Counter: xfer_count increments on each out_valid && out_ready and saturates at all-ones; it does not wrap.
- FSM:
  - RUN: cfg_start=1 moves to DRAIN; the input is refused in that cycle.
  - DRAIN: moves to LOAD in the cycle out_valid==0, evaluated on registered state. If out_valid is already 0 when entering DRAIN, DRAIN lasts exactly one cycle.
  - LOAD: cfg_we=1 writes table[cfg_addr] <= cfg_data at the edge. cfg_done=1 moves to RUN. If cfg_we and cfg_done are both high in the same cycle, the write is performed and the state still returns to RUN.
- Ignored inputs: cfg_we outside LOAD, cfg_start outside RUN, cfg_done outside LOAD. Multiple writes to one address keep the last value.
- First lookup after LOAD→RUN sees all writes made in LOAD.
- in_ready is 0 in DRAIN and LOAD. out_ready is still honoured in DRAIN so the pipeline can empty.
- Reset mid-LOAD restores INIT_TABLE and discards partial writes. Reset mid-transfer drops the output word.

Decomposition:
- Shared package lut_neuron_pkg: mode typedef enum logic [1:0] {RUN, DRAIN, LOAD} and MODE_W=2.
- Sub-module lut_neuron_table: flop array with reset to INIT_TABLE, one async read port, one sync write port.
- The top level holds the FSM, output register, handshake logic and counter.

Test Plan:
- Reset, then stream in_data 0..63 with out_ready=1 → out_valid rises 1 cycle after the first accept; outputs are 00,00,11,11 repeating; xfer_count=64; in_ready stays 1 throughout.
- Backpressure: accept in_data=6'd2, hold out_ready=0 for 5 cycles → out_data=2'b11 stable, in_ready=0; release → one handshake, xfer_count+1.
- Reload: cfg_start while out_valid=1 and out_ready=0 → mode=DRAIN until out_ready; then LOAD. Write addr 0→2'b10 and addr 63→2'b01 with cfg_done on the last write. Lookups of 0 and 63 → 2'b10 and 2'b01.
- Illegal config: cfg_we with addr 5/data 2'b11 in RUN, and cfg_done in RUN → table unchanged (lookup 5 → 2'b00), mode stays RUN.
- Reset during LOAD after writing addr 0=2'b11 → lookup 0 returns 2'b00; mode=RUN; out_valid=0.
- Saturation with CNT_BITS=4: 20 handshakes → xfer_count=4'hF.
